// File: rtl/mmio_pkg.sv
// Shared encodings for the M-stage MMIO bridge: access sizes, FSM states, decode regions
// and the byte-lane helpers used for DM stores.
package mmio_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        DM,
        TMR,
        INT,
        NONE
    } region_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
    } pr_req_t;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_WORD: be = 4'b1111;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: be = 4'b0001 << lo;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wd(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        d = wd;
        case (size)
            SZ_HALF: d = {2{wd[15:0]}};
            SZ_BYTE: d = {4{wd[7:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mmio_bridge_n_if.sv
// CPU / DM / peripheral signal bundle of the MMIO bridge.
// slave is the bridge side, master is the CPU+memory+devices side.
interface mmio_bridge_n_if #(
    parameter int N_TIMER = 2
);
    logic                         cpu_req;
    logic                         cpu_we;
    logic [1:0]                   cpu_size;
    logic [31:0]                  cpu_addr;
    logic [31:0]                  cpu_wd;
    logic [31:0]                  cpu_rd;
    logic                         cpu_stall;
    logic                         cpu_err;
    logic [3:0]                   dm_byteen;
    logic [31:0]                  dm_wd;
    logic [31:0]                  dm_rd;
    logic [N_TIMER:0]             pr_sel;
    logic                         pr_we;
    logic [31:0]                  pr_addr;
    logic [31:0]                  pr_wd;
    logic [32*(N_TIMER+1)-1:0]    pr_rd;
    logic [N_TIMER:0]             pr_ack;

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wd, dm_rd, pr_rd, pr_ack,
        output cpu_rd, cpu_stall, cpu_err, dm_byteen, dm_wd, pr_sel, pr_we, pr_addr, pr_wd
    );

    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wd, dm_rd, pr_rd, pr_ack,
        input  cpu_rd, cpu_stall, cpu_err, dm_byteen, dm_wd, pr_sel, pr_we, pr_addr, pr_wd
    );
endinterface

// File: rtl/mmio_addr_decode.sv
// Purpose: classify a CPU byte address into DM / timer k / interrupt generator / unmapped.
// Latency: purely combinational.
// Backpressure: none; no state.
module mmio_addr_decode
    import mmio_pkg::*;
#(
    parameter int          N_TIMER      = 2,
    parameter logic [31:0] DM_TOP       = 32'h2fff,
    parameter logic [31:0] TIMER_BASE   = 32'h7f00,
    parameter logic [31:0] TIMER_STRIDE = 32'h10,
    parameter int          TIMER_SPAN   = 12,
    parameter logic [31:0] INT_BASE     = 32'h7f20,
    parameter int          CH_W         = $clog2(N_TIMER + 1)
) (
    input  logic [31:0]     addr,
    input  logic [1:0]      size,
    output region_t         region,
    output logic [CH_W-1:0] ch,
    output logic            misalign,
    output logic            bad_size
);

    always_comb begin
        region = NONE;
        ch     = '0;
        if (addr <= DM_TOP) begin
            region = DM;
        end else begin
            // Unsigned offset compare: addresses below a base wrap to huge values.
            for (int k = 0; k < N_TIMER; k++) begin
                if ((addr - (TIMER_BASE + TIMER_STRIDE * 32'(k))) < 32'(TIMER_SPAN)) begin
                    region = TMR;
                    ch     = CH_W'(k);
                end
            end
            if (region == NONE && (addr - INT_BASE) < 32'd4) begin
                region = INT;
                ch     = CH_W'(N_TIMER);
            end
        end
    end

    assign misalign = (size == SZ_WORD && addr[1:0] != 2'b00) ||
                      (size == SZ_HALF && addr[0]);

    assign bad_size = (size == 2'd3) ||
                      ((region == TMR || region == INT) && size != SZ_WORD);

endmodule

// File: rtl/mmio_bridge_n.sv
// Purpose: M-stage bridge steering CPU loads/stores to DM, N timers and the interrupt generator.
// Latency: DM and bus errors 0 cycles; peripherals 1 + ack delay + 1 cycles.
// Backpressure: cpu_stall held while a peripheral is pending; aborts with error after TIMEOUT.
module mmio_bridge_n
    import mmio_pkg::*;
#(
    parameter int          N_TIMER      = 2,
    parameter logic [31:0] DM_TOP       = 32'h2fff,
    parameter logic [31:0] TIMER_BASE   = 32'h7f00,
    parameter logic [31:0] TIMER_STRIDE = 32'h10,
    parameter int          TIMER_SPAN   = 12,
    parameter logic [31:0] INT_BASE     = 32'h7f20,
    parameter int          TIMEOUT      = 15
) (
    input logic            clk,
    input logic            reset,
    mmio_bridge_n_if.slave bus
);

    localparam int                CH_W     = $clog2(N_TIMER + 1);
    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    pr_req_t           req_q, req_d;
    logic [N_TIMER:0]  sel_q, sel_d;
    logic              we_q, we_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    region_t           dec_region;
    logic [CH_W-1:0]   dec_ch;
    logic              dec_mis;
    logic              dec_bad;
    logic              acc_err;
    logic              req_ok;
    logic              ack_hit;
    logic [31:0]       ch_rd;

    logic [31:0]       cpu_rd;
    logic              cpu_stall;
    logic              cpu_err;
    logic [3:0]        dm_byteen;

    mmio_addr_decode #(
        .N_TIMER      (N_TIMER),
        .DM_TOP       (DM_TOP),
        .TIMER_BASE   (TIMER_BASE),
        .TIMER_STRIDE (TIMER_STRIDE),
        .TIMER_SPAN   (TIMER_SPAN),
        .INT_BASE     (INT_BASE),
        .CH_W         (CH_W)
    ) u_decode (
        .addr     (bus.cpu_addr),
        .size     (bus.cpu_size),
        .region   (dec_region),
        .ch       (dec_ch),
        .misalign (dec_mis),
        .bad_size (dec_bad)
    );

    // Gating with reset keeps stall/err/enables low while reset is held, even with cpu_req up.
    assign req_ok  = bus.cpu_req & ~reset;
    assign acc_err = dec_mis | dec_bad | (dec_region == NONE);
    assign ack_hit = bus.pr_ack[ch_q];
    assign ch_rd   = bus.pr_rd[32*ch_q +: 32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        sel_d     = sel_q;
        we_d      = we_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cpu_rd    = '0;
        cpu_stall = 1'b0;
        cpu_err   = 1'b0;
        dm_byteen = '0;

        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    if (acc_err) begin
                        cpu_err = 1'b1;
                    end else if (dec_region == DM) begin
                        cpu_rd = bus.dm_rd;
                        if (bus.cpu_we) begin
                            dm_byteen = lane_be(bus.cpu_size, bus.cpu_addr[1:0]);
                        end
                    end else begin
                        cpu_stall     = 1'b1;
                        req_d         = '{addr: bus.cpu_addr, wd: bus.cpu_wd};
                        sel_d         = '0;
                        sel_d[dec_ch] = 1'b1;
                        we_d          = bus.cpu_we;
                        ch_d          = dec_ch;
                        cnt_d         = '0;
                        err_d         = 1'b0;
                        state_d       = WAIT;
                    end
                end
            end
            WAIT: begin
                cpu_stall = 1'b1;
                if (ack_hit) begin
                    // Ack beats a timeout landing in the same cycle.
                    rdata_d = ch_rd;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        sel_d   = '0;
                        we_d    = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // The stalled instruction retires here; a held cpu_req belongs to it.
                cpu_rd  = rdata_q;
                cpu_err = err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            ch_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            req_q   <= req_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.cpu_rd    = cpu_rd;
    assign bus.cpu_stall = cpu_stall;
    assign bus.cpu_err   = cpu_err;
    assign bus.dm_byteen = dm_byteen;
    assign bus.dm_wd     = lane_wd(bus.cpu_size, bus.cpu_wd);
    assign bus.pr_sel    = sel_q;
    assign bus.pr_we     = we_q;
    assign bus.pr_addr   = req_q.addr;
    assign bus.pr_wd     = req_q.wd;

endmodule

// File: tb/tb_mmio_bridge_n.sv
// Purpose: directed plus randomized checking of mmio_bridge_n against an address-map model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: the bench follows the model's expected stall length for every peripheral access.
module tb_mmio_bridge_n;
    import mmio_pkg::*;

    localparam int          NT        = 2;
    localparam logic [31:0] DM_TOP    = 32'h2fff;
    localparam logic [31:0] TB_BASE   = 32'h7f00;
    localparam logic [31:0] TB_STRIDE = 32'h10;
    localparam int          SPAN      = 12;
    localparam logic [31:0] INT_BASE  = 32'h7f20;
    localparam int          TIMEOUT   = 15;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mmio_bridge_n_if #(.N_TIMER(NT)) bus ();

    mmio_bridge_n #(
        .N_TIMER      (NT),
        .DM_TOP       (DM_TOP),
        .TIMER_BASE   (TB_BASE),
        .TIMER_STRIDE (TB_STRIDE),
        .TIMER_SPAN   (SPAN),
        .INT_BASE     (INT_BASE),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // -2 = DM, -1 = unmapped, 0..NT-1 = timer, NT = interrupt generator
    function automatic int chan_of(input logic [31:0] a);
        if (a <= DM_TOP) return -2;
        for (int k = 0; k < NT; k++) begin
            if (a >= TB_BASE + TB_STRIDE * 32'(k) && a < TB_BASE + TB_STRIDE * 32'(k) + 32'(SPAN))
                return k;
        end
        if (a >= INT_BASE && a <= INT_BASE + 32'd3) return NT;
        return -1;
    endfunction

    function automatic bit legal(input logic [1:0] sz, input logic [31:0] a, input int c);
        if (c == -1 || sz == 2'd3) return 1'b0;
        if (sz == SZ_WORD && (a % 4) != 0) return 1'b0;
        if (sz == SZ_HALF && (a % 2) != 0) return 1'b0;
        if (c >= 0 && sz != SZ_WORD) return 1'b0;
        return 1'b1;
    endfunction

    // Single-cycle access: legal DM load/store or any erroring access.
    task automatic dm_access(input logic we, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd);
        int          c;
        bit          ok;
        logic [31:0] dmv;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        c      = chan_of(a);
        ok     = legal(sz, a, c);
        dmv    = $urandom;
        exp_be = 4'h0;
        if (ok && we) begin
            if (sz == SZ_BYTE)      exp_be = 4'(32'd1 << (a % 4));
            else if (sz == SZ_HALF) exp_be = ((a % 4) == 2) ? 4'hc : 4'h3;
            else                    exp_be = 4'hf;
        end
        if (sz == SZ_BYTE)      exp_wd = 32'h01010101 * {24'h0, wd[7:0]};
        else if (sz == SZ_HALF) exp_wd = 32'h00010001 * {16'h0, wd[15:0]};
        else                    exp_wd = wd;
        @(posedge clk); #1;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = we;
        bus.cpu_size = sz;
        bus.cpu_addr = a;
        bus.cpu_wd   = wd;
        bus.dm_rd    = dmv;
        #4;
        chk("acc_err",   32'(bus.cpu_err),   32'(!ok));
        chk("acc_stall", 32'(bus.cpu_stall), 32'd0);
        chk("acc_be",    32'(bus.dm_byteen), 32'(exp_be));
        chk("acc_sel",   32'(bus.pr_sel),    32'd0);
        chk("acc_rd",    bus.cpu_rd,         ok ? dmv : 32'd0);
        if (ok && we) chk("acc_wd", bus.dm_wd, exp_wd);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        #4;
        chk("err_pulse", 32'(bus.cpu_err), 32'd0);
    endtask

    // Peripheral word access; ack_at = WAIT cycle (1-based) of the selected ack, 0 = none.
    task automatic pr_xfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rdv, input logic [NT:0] noise);
        int                      c;
        int                      n_wait;
        bit                      to;
        logic [NT:0]             s;
        logic [32*(NT+1)-1:0]    rdb;
        c      = chan_of(a);
        s      = '0;
        s[c]   = 1'b1;
        to     = (ack_at < 1 || ack_at > TIMEOUT);
        n_wait = to ? TIMEOUT : ack_at;
        for (int k = 0; k <= NT; k++) rdb[32*k +: 32] = (k == c) ? rdv : $urandom;
        @(posedge clk); #1;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = we;
        bus.cpu_size = SZ_WORD;
        bus.cpu_addr = a;
        bus.cpu_wd   = wd;
        bus.pr_rd    = rdb;
        bus.pr_ack   = noise & ~s;
        #4;
        chk("req_stall", 32'(bus.cpu_stall), 32'd1);
        chk("req_err",   32'(bus.cpu_err),   32'd0);
        chk("req_be",    32'(bus.dm_byteen), 32'd0);
        for (int w = 1; w <= n_wait; w++) begin
            @(posedge clk); #1;
            bus.pr_ack = (noise & ~s) | ((w == ack_at) ? s : '0);
            #4;
            chk("wait_stall", 32'(bus.cpu_stall), 32'd1);
            chk("wait_sel",   32'(bus.pr_sel),    32'(s));
            chk("wait_addr",  bus.pr_addr,        a);
            chk("wait_wd",    bus.pr_wd,          wd);
            chk("wait_we",    32'(bus.pr_we),     32'(we));
        end
        @(posedge clk); #1;
        bus.pr_ack = '0;
        #4;
        chk("done_stall", 32'(bus.cpu_stall), 32'd0);
        chk("done_sel",   32'(bus.pr_sel),    32'd0);
        chk("done_rd",    bus.cpu_rd,         to ? 32'd0 : rdv);
        chk("done_err",   32'(bus.cpu_err),   32'(to));
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        #4;
        chk("post_stall", 32'(bus.cpu_stall), 32'd0);
        chk("post_sel",   32'(bus.pr_sel),    32'd0);
        chk("post_err",   32'(bus.cpu_err),   32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          c;

        bus.cpu_req  = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.cpu_size = SZ_WORD;
        bus.cpu_addr = '0;
        bus.cpu_wd   = '0;
        bus.dm_rd    = '0;
        bus.pr_rd    = '0;
        bus.pr_ack   = '0;

        // Reset state
        #1 reset = 1'b1;
        #2;
        chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_err",   32'(bus.cpu_err),   32'd0);
        chk("rst_sel",   32'(bus.pr_sel),    32'd0);
        chk("rst_we",    32'(bus.pr_we),     32'd0);
        chk("rst_addr",  bus.pr_addr,        32'd0);
        chk("rst_wd",    bus.pr_wd,          32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;

        // DM lanes and region boundary
        dm_access(1'b1, SZ_BYTE, 32'h1003, 32'h12);
        dm_access(1'b1, SZ_HALF, 32'h2002, 32'hbeef);
        dm_access(1'b1, SZ_WORD, 32'h0100, 32'h89abcdef);
        dm_access(1'b0, SZ_WORD, 32'h2ffc, 32'h0);
        dm_access(1'b0, SZ_BYTE, 32'h3000, 32'h0);

        // Timer 1 read, ack in third WAIT cycle
        pr_xfer(1'b0, 32'h7f14, 32'h0, 3, 32'hCAFE0001, '0);
        // Interrupt-generator write with no ack: timeout
        pr_xfer(1'b1, 32'h7f20, 32'h5a5a5a5a, 0, 32'h0, '0);

        // Bus errors
        dm_access(1'b0, SZ_WORD, 32'h7f02, 32'h0);
        dm_access(1'b1, SZ_BYTE, 32'h7f00, 32'h77);
        dm_access(1'b0, SZ_WORD, 32'h5000, 32'h0);
        dm_access(1'b0, SZ_WORD, 32'h7f0c, 32'h0);
        dm_access(1'b0, SZ_HALF, 32'h0101, 32'h0);

        // Reset in the second WAIT cycle
        @(posedge clk); #1;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b1;
        bus.cpu_size = SZ_WORD;
        bus.cpu_addr = 32'h7f00;
        bus.cpu_wd   = 32'hdeadbeef;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rw_stall", 32'(bus.cpu_stall), 32'd1);
        chk("rw_sel",   32'(bus.pr_sel),    32'd1);
        chk("rw_we",    32'(bus.pr_we),     32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_sel",   32'(bus.pr_sel),    32'd0);
        chk("rst_mid_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_mid_we",    32'(bus.pr_we),     32'd0);
        @(posedge clk); #1;
        reset       = 1'b0;
        bus.cpu_req = 1'b0;
        #4;
        chk("rst_after_sel", 32'(bus.pr_sel), 32'd0);
        pr_xfer(1'b0, 32'h7f00, 32'h0, 1, 32'h11223344, '0);

        // Foreign acks ignored; ack coinciding with the timeout cycle wins
        pr_xfer(1'b0, 32'h7f08, 32'h0, 2, 32'h0badcafe, 3'b110);
        pr_xfer(1'b0, 32'h7f04, 32'h0, 0, 32'h12345678, 3'b110);
        pr_xfer(1'b0, 32'h7f00, 32'h0, TIMEOUT, 32'h600df00d, 3'b110);

        // Randomized traffic over the whole map
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 32'h2fff));
                1:       a = TB_BASE + 32'($urandom_range(0, 31));
                2:       a = INT_BASE + 32'($urandom_range(0, 7));
                default: a = $urandom;
            endcase
            sz = 2'($urandom_range(0, 3));
            if (a >= TB_BASE && a < TB_BASE + 32'h28 && $urandom_range(0, 3) != 0) begin
                a[1:0] = 2'b00;
                sz     = SZ_WORD;
            end
            c = chan_of(a);
            if (legal(sz, a, c) && c >= 0)
                pr_xfer(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, TIMEOUT + 3),
                        $urandom, (NT+1)'($urandom_range(0, 7)));
            else
                dm_access(1'($urandom_range(0, 1)), sz, a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
